spi_word_sequencer: RTL and testbench
=====================================

# spi_word_sequencer

Upstream command stage for the 16-bit SPI word transmitter. Buffers 16-bit words from the ASCON-side producer in a small FIFO. Launches each word into the transmitter with a single start pulse, and holds the word stable while the transmitter sends the low byte then the high byte. Collects the two MISO bytes returned per word into one 16-bit receive word.

## Interface
Parameters:
- FIFO_DEPTH, 8 — word FIFO depth; power of two, ≥2.
- GAP_CYCLES, 2 — minimum idle cycles between the end of one word and the next o_Start; ≥2.
- TIMEOUT_CYCLES, 1023 — maximum cycles to wait for each received byte before aborting; ≥16.

Ports:
- i_Clk  in  1  — the single clock.
- i_Rst_L  in  1  — reset; synchronous, active-low.
- i_Wr_Valid  in  1  — push request.
- i_Wr_Data  in  16  — word to push.
- o_Wr_Ready  out  1  — FIFO not full; a push happens when i_Wr_Valid && o_Wr_Ready.
- o_Start  out  1  — one-cycle start pulse to the transmitter.
- o_TX_Word  out  16  — word under transmission; drives the transmitter's 16-bit TX input.
- i_RX_DV  in  1  — per-byte receive strobe from the transmitter.
- i_RX_Byte  in  8  — received byte, valid with i_RX_DV.
- o_RX_Valid  out  1  — one-cycle pulse; o_RX_Word valid.
- o_RX_Word  out  16  — {second byte, first byte}.
- o_Busy  out  1  — FSM not in IDLE.
- o_Level  out  $clog2(FIFO_DEPTH)+1  — FIFO occupancy.
- o_Timeout  out  1  — sticky abort flag.

## Operation
- FIFO behaviour:
  - Registered circular buffer with wrapping read and write pointers, plus an occupancy count.
  - o_Wr_Ready = (o_Level != FIFO_DEPTH), computed from the registered level.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - Push and pop in the same cycle: o_Level is unchanged and both pointers advance.
- FSM states: IDLE, START, WAIT_LO, WAIT_HI, GAP.
  - IDLE: if o_Level>0 and o_Timeout==0, pop the head into o_TX_Word at this edge and go to START.
  - START: o_Start=1 for this cycle only; go to WAIT_LO.
  - WAIT_LO: on i_RX_DV, capture i_RX_Byte into the low holding register and go to WAIT_HI.
  - WAIT_HI: on i_RX_DV:
    - o_RX_Word <= {i_RX_Byte, low}.
    - o_RX_Valid <= 1 for the next cycle.
    - Go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- o_TX_Word holds its value from the pop until the next pop. The transmitter samples the high byte directly from its input after the low byte, so o_TX_Word must not change before GAP.
- i_RX_DV in IDLE, START or GAP is ignored.
- Timeout:
  - A wait counter clears on entry to WAIT_LO and WAIT_HI and on every i_RX_DV.
  - When the counter reaches TIMEOUT_CYCLES in either wait state:
    - o_Timeout <= 1.
    - The word is discarded and no o_RX_Valid is issued.
    - Go to IDLE.
  - While o_Timeout=1, no new o_Start is issued because transmitter byte-phase is unknown. The FIFO still accepts pushes.
  - o_Timeout clears only on reset; recovery is a common reset of this block and the transmitter.
- Reset (i_Rst_L low at an edge, including mid-word):
  - FSM → IDLE; pointers, level and counters cleared.
  - All outputs 0: o_Wr_Ready is 1 from the first cycle after reset release.
  - FIFO contents are discarded.

## Timing
- Pop to o_Start latency: the word pops at edge E (IDLE→START); o_Start is high for the cycle after E.
- Push into an empty idle block at edge P:
  - o_Level=1 after P.
  - Pop at P+1.
  - o_Start high during the cycle P+1..P+2.
- Second i_RX_DV sampled at edge H: o_RX_Valid high for cycle H..H+1, GAP begins at H, earliest next o_Start is GAP_CYCLES+1 cycles later.
- Throughput: one word per (transmitter word time + GAP_CYCLES + 3) cycles.
- o_Start never asserts in two consecutive cycles, and never outside START.
- o_Busy = (state != IDLE), registered.

## Test plan
- Reset mid-WAIT_HI with 3 words queued -> next cycle all outputs 0, o_Level=0, o_Wr_Ready=1, no o_Start until a new push.
- Push 0xA55A into an empty block; transmitter model returns bytes 0x3C then 0xC3 -> exactly one o_Start; o_TX_Word=0xA55A until GAP; one o_RX_Valid with o_RX_Word=0xC33C.
- Push 0x0001..0x0008 back-to-back with FIFO_DEPTH=8 and the transmitter stalled -> o_Wr_Ready drops after the 8th accepted push; a 9th push (0x0009) is dropped; words are transmitted in order 0x0001..0x0008 with o_Start spacing ≥ GAP_CYCLES+3.
- With o_Level=FIFO_DEPTH in IDLE, push in the same cycle as the pop -> push dropped, o_Level=FIFO_DEPTH-1.
- Simultaneous push and pop at o_Level=3 -> o_Level stays 3; pointers wrap correctly across 20 words; FIFO order preserved.
- Withhold the second i_RX_DV for TIMEOUT_CYCLES cycles -> o_Timeout=1, no o_RX_Valid, FSM to IDLE, no further o_Start despite o_Level=2; after reset, o_Timeout=0.

Source files
------------

// File: rtl/spi_word_sequencer.sv
// Command stage in front of the 16-bit SPI word transmitter: buffers words in a
// small FIFO, launches each with a single start pulse, keeps the word stable
// while both bytes go out, and assembles the two returned MISO bytes.
module spi_word_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Wr_Valid,
    input  logic [15:0]                   i_Wr_Data,
    output logic                          o_Wr_Ready,
    output logic                          o_Start,
    output logic [15:0]                   o_TX_Word,
    input  logic                          i_RX_DV,
    input  logic [7:0]                    i_RX_Byte,
    output logic                          o_RX_Valid,
    output logic [15:0]                   o_RX_Word,
    output logic                          o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level,
    output logic                          o_Timeout
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LvlW-1:0]  LevelFull = LvlW'(FIFO_DEPTH);
    localparam logic [GapW-1:0]  GapLast   = GapW'(GAP_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]        low_q, low_d;
    logic [15:0]       tx_word_q;
    logic [15:0]       rx_word_q, rx_word_d;
    logic              rx_valid_q, rx_valid_d;
    logic              timeout_q, timeout_d;
    logic              push, pop, full;

    // Ready comes from the registered level, so a push while full is dropped
    // even when a pop happens on the same edge.
    assign full       = (level_q == LevelFull);
    assign push       = i_Wr_Valid && !full;

    assign o_Wr_Ready = !full;
    assign o_Start    = (state_q == StStart);
    assign o_Busy     = (state_q != StIdle);
    assign o_TX_Word  = tx_word_q;
    assign o_RX_Valid = rx_valid_q;
    assign o_RX_Word  = rx_word_q;
    assign o_Level    = level_q;
    assign o_Timeout  = timeout_q;

    // FIFO storage; contents need no reset since pointers and level do.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_Wr_Data;
        end
    end

    // Next-state, counters and receive assembly.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        wait_cnt_d = wait_cnt_q;
        low_d      = low_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = 1'b0;
        timeout_d  = timeout_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                // After an abort the transmitter byte phase is unknown: hold off.
                if ((level_q != '0) && !timeout_q) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                wait_cnt_d = '0;
                state_d    = StWaitLo;
            end
            StWaitLo: begin
                if (i_RX_DV) begin
                    low_d      = i_RX_Byte;
                    wait_cnt_d = '0;
                    state_d    = StWaitHi;
                end else if (wait_cnt_q == WaitLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StWaitHi: begin
                if (i_RX_DV) begin
                    rx_word_d  = {i_RX_Byte, low_q};
                    rx_valid_d = 1'b1;
                    wait_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = StGap;
                end else if (wait_cnt_q == WaitLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, FIFO bookkeeping and output registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
            low_q      <= '0;
            tx_word_q  <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            low_q      <= low_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            timeout_q  <= timeout_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PtrW'(1);
                // Held until the next pop; the transmitter re-reads the high byte.
                tx_word_q <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer: directed scenarios, a transaction-level model
// (word queue, level count, expected receive words) checked every cycle, plus
// hand-computed literal expectations.
module tb_spi_word_sequencer;

    localparam int unsigned Depth = 8;
    localparam int unsigned Gap   = 2;
    localparam int unsigned Tmo   = 32;
    localparam int unsigned LvlW  = $clog2(Depth) + 1;

    logic            clk      = 1'b0;
    logic            rst_l    = 1'b0;
    logic            wr_valid = 1'b0;
    logic [15:0]     wr_data  = '0;
    logic            rx_dv    = 1'b0;
    logic [7:0]      rx_byte  = '0;
    logic            wr_ready, start, rx_valid, busy, timeout;
    logic [15:0]     tx_word, rx_word;
    logic [LvlW-1:0] level;

    always #5 clk = ~clk;

    spi_word_sequencer #(
        .FIFO_DEPTH     (Depth),
        .GAP_CYCLES     (Gap),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Wr_Valid (wr_valid),
        .i_Wr_Data  (wr_data),
        .o_Wr_Ready (wr_ready),
        .o_Start    (start),
        .o_TX_Word  (tx_word),
        .i_RX_DV    (rx_dv),
        .i_RX_Byte  (rx_byte),
        .o_RX_Valid (rx_valid),
        .o_RX_Word  (rx_word),
        .o_Busy     (busy),
        .o_Level    (level),
        .o_Timeout  (timeout)
    );

    // Inputs as the DUT saw them at the last rising edge.
    logic        s_rst = 1'b0;
    logic        s_wv  = 1'b0;
    logic [15:0] s_wd  = '0;
    always @(posedge clk) begin
        s_rst <= rst_l;
        s_wv  <= wr_valid;
        s_wd  <= wr_data;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    int          mdl_level   = 0;
    logic [15:0] mdl_cur     = '0;
    bit          mdl_to      = 1'b0;
    bit          hi_withheld = 1'b0;
    int          withheld_cyc = 0;
    int          to_delta    = -1;
    int          gen         = 0;
    bit          have_start  = 1'b0;
    int          last_start  = 0;
    int          start_count = 0;

    // Transmitter model state
    bit          xm_active  = 1'b0;
    bit          xm_phase   = 1'b0;
    int          xm_cnt     = 0;
    int          xm_gen     = 0;
    int          byte_delay = 4;
    bit          drop_hi    = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        if (!s_rst) begin
            tx_q.delete();
            rx_q.delete();
            mdl_level   = 0;
            mdl_cur     = '0;
            mdl_to      = 1'b0;
            hi_withheld = 1'b0;
            have_start  = 1'b0;
            gen++;
            chk("rst_start", start, 0);
            chk("rst_tx_word", tx_word, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_rx_word", rx_word, 0);
            chk("rst_busy", busy, 0);
            chk("rst_level", level, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_wr_ready", wr_ready, 1);
        end else begin
            if (s_wv && (mdl_level != Depth)) begin
                tx_q.push_back(s_wd);
                mdl_level++;
            end
            if (start) begin
                start_count++;
                chk("start_legal", (tx_q.size() != 0) && !mdl_to, 1);
                if (tx_q.size() != 0) begin
                    chk("tx_order", tx_word, tx_q[0]);
                    mdl_cur = tx_q.pop_front();
                    mdl_level--;
                end
                if (have_start) chk("start_spacing", (cyc - last_start) >= (Gap + 3), 1);
                chk("busy_in_start", busy, 1);
                have_start = 1'b1;
                last_start = cyc;
            end
            chk("level", level, mdl_level);
            chk("wr_ready", wr_ready, mdl_level != Depth);
            chk("tx_word_hold", tx_word, mdl_cur);
            if (rx_valid) begin
                chk("rx_expected", rx_q.size() != 0, 1);
                if (rx_q.size() != 0) chk("rx_word", rx_word, rx_q.pop_front());
                chk("busy_in_gap", busy, 1);
            end
            if (timeout && !mdl_to) begin
                chk("timeout_cause", hi_withheld, 1);
                mdl_to   = 1'b1;
                to_delta = cyc - withheld_cyc;
            end else if (mdl_to) begin
                chk("timeout_sticky", timeout, 1);
            end
        end
    endtask

    // Transmitter: returns word ^ 0x6666, low byte first, high byte re-read
    // from o_TX_Word when it is sent.
    task automatic xmit_step();
        rx_dv = 1'b0;
        if (start && !xm_active) begin
            xm_active = 1'b1;
            xm_phase  = 1'b0;
            xm_cnt    = byte_delay;
            xm_gen    = gen;
        end else if (xm_active) begin
            if (xm_cnt > 0) begin
                xm_cnt--;
            end else if (!xm_phase) begin
                rx_dv    = 1'b1;
                rx_byte  = tx_word[7:0] ^ 8'h66;
                xm_phase = 1'b1;
                xm_cnt   = byte_delay;
                if (drop_hi) begin
                    xm_active    = 1'b0;
                    hi_withheld  = 1'b1;
                    withheld_cyc = cyc;
                end
            end else begin
                rx_dv     = 1'b1;
                rx_byte   = tx_word[15:8] ^ 8'h66;
                xm_active = 1'b0;
                xm_phase  = 1'b0;
                if (xm_gen == gen) rx_q.push_back(mdl_cur ^ 16'h6666);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare_cycle();
        xmit_step();
    endtask

    task automatic push(input logic [15:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (((level != 0) || busy || xm_active) && (n < 600)) begin
            tick();
            n++;
        end
        chk(name, (level == 0) && !busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int sc;

        rst_l = 1'b0;
        repeat (3) tick();
        rst_l = 1'b1;
        tick();
        chk("init_level", level, 0);
        chk("init_ready", wr_ready, 1);
        chk("init_busy", busy, 0);

        // Reset in WAIT_HI with three words queued.
        byte_delay = 6;
        for (int i = 0; i < 4; i++) push(16'(16'h4000 + i));
        n = 0;
        while (!xm_phase && (n < 60)) begin
            tick();
            n++;
        end
        chk("reach_wait_hi", xm_phase, 1);
        tick();
        tick();
        chk("midword_busy", busy, 1);
        chk("midword_level", level, 3);
        sc = start_count;
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("r_start", start, 0);
        chk("r_tx_word", tx_word, 0);
        chk("r_rx_valid", rx_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_level", level, 0);
        chk("r_wr_ready", wr_ready, 1);
        repeat (30) tick();
        chk("no_start_after_reset", start_count - sc, 0);

        // Single word 0xA55A, transmitter answers 0x3C then 0xC3.
        byte_delay = 4;
        sc = start_count;
        push(16'hA55A);
        chk("a55a_level_after_push", level, 1);
        chk("a55a_no_start_yet", start, 0);
        tick();
        chk("a55a_start", start, 1);
        chk("a55a_tx_word", tx_word, 16'hA55A);
        chk("a55a_level_after_pop", level, 0);
        n = 0;
        while (!rx_valid && (n < 80)) begin
            tick();
            n++;
        end
        chk("a55a_rx_seen", rx_valid, 1);
        chk("a55a_rx_word", rx_word, 16'hC33C);
        chk("a55a_tx_in_gap", tx_word, 16'hA55A);
        wait_drained("a55a_idle");
        chk("a55a_one_start", start_count - sc, 1);

        // Fill the FIFO behind a slow in-flight word.
        byte_delay = 20;
        push(16'h00F0);
        for (int i = 1; i <= 8; i++) push(16'(i));
        chk("full_ready", wr_ready, 0);
        chk("full_level", level, 8);
        push(16'h0009);
        chk("drop_when_full", level, 8);
        byte_delay = 2;
        n = 0;
        while (busy && (n < 120)) begin
            tick();
            n++;
        end
        chk("idle_full_level", level, 8);
        // Push on the very edge that pops: must be dropped.
        wr_valid = 1'b1;
        wr_data  = 16'h0099;
        tick();
        wr_valid = 1'b0;
        chk("pop_push_full_level", level, 7);
        chk("pop_push_full_start", start, 1);
        chk("pop_push_full_tx", tx_word, 16'h0001);
        wait_drained("full_drained");

        // Hold level at 3 with push and pop on the same edge, 20 words.
        byte_delay = 20;
        for (int i = 0; i < 4; i++) push(16'(16'h1000 + i));
        chk("steady_level_init", level, 3);
        byte_delay = 4;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (busy && (n < 100)) begin
                tick();
                n++;
            end
            wr_valid = 1'b1;
            wr_data  = 16'(16'h2000 + i);
            tick();
            wr_valid = 1'b0;
            chk("steady_level", level, 3);
            chk("steady_start", start, 1);
        end
        wait_drained("steady_drained");

        // Withhold the second byte: abort, then stay quiet until reset.
        drop_hi    = 1'b1;
        byte_delay = 3;
        for (int i = 0; i < 3; i++) push(16'(16'h3000 + i));
        n = 0;
        while (!timeout && (n < Tmo + 60)) begin
            tick();
            n++;
        end
        chk("timeout_set", timeout, 1);
        checks++;
        if ((to_delta < Tmo + 1) || (to_delta > Tmo + 2)) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d",
                     to_delta, Tmo + 1, Tmo + 2);
        end
        chk("timeout_level", level, 2);
        chk("timeout_idle", busy, 0);
        sc = start_count;
        repeat (20) tick();
        chk("timeout_no_start", start_count - sc, 0);
        push(16'h3003);
        chk("timeout_push_level", level, 3);
        chk("timeout_still_set", timeout, 1);
        drop_hi = 1'b0;
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("timeout_cleared", timeout, 0);
        chk("timeout_rst_level", level, 0);
        tick();
        chk("timeout_rst_ready", wr_ready, 1);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
